// File: rtl/asi_reconfig_sequencer_if.sv
// Config and datapath handshake bundle between the ASI reconfig sequencer,
// the CPU config registers and the ASI write ctrl / FIFO / read ctrl.
interface asi_reconfig_sequencer_if;
  logic       i_BtsComp;
  logic       i_AsiMode;
  logic       i_ReqAlteraModo;
  logic       i_PktEnd;
  logic       i_RdBusy;
  logic       i_FifoEmpty;
  logic [7:0] o_PacketLength;
  logic       o_AsiMode;
  logic       o_RdHold;
  logic       o_FifoClr;
  logic       o_Busy;
  logic       o_CfgDone;
  logic       o_DrainTimeout;
  logic [7:0] o_ChangeCount;

  modport master (
    output i_BtsComp, i_AsiMode, i_ReqAlteraModo,
    output i_PktEnd, i_RdBusy, i_FifoEmpty,
    input  o_PacketLength, o_AsiMode, o_RdHold, o_FifoClr,
    input  o_Busy, o_CfgDone, o_DrainTimeout, o_ChangeCount
  );

  modport slave (
    input  i_BtsComp, i_AsiMode, i_ReqAlteraModo,
    input  i_PktEnd, i_RdBusy, i_FifoEmpty,
    output o_PacketLength, o_AsiMode, o_RdHold, o_FifoClr,
    output o_Busy, o_CfgDone, o_DrainTimeout, o_ChangeCount
  );
endinterface

// File: rtl/asi_reconfig_sequencer.sv
// ASI output-path reconfig sequencer: drain the in-flight packet, clear the
// FIFO, load the new packet length / mode, settle, then release reads.
module asi_reconfig_sequencer #(
  parameter int unsigned CLR_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned DRAIN_TIMEOUT = 408
) (
  input logic i_Clk27Mhz,
  input logic i_Rst27Mhz,
  asi_reconfig_sequencer_if.slave bus
);
  localparam int unsigned MaxAb =
    (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxC =
    (MaxAb > DRAIN_TIMEOUT) ? MaxAb : DRAIN_TIMEOUT;
  localparam int unsigned CW = $clog2(MaxC + 1);

  localparam logic [CW-1:0] ClrLast = CW'(CLR_CYCLES - 1);
  localparam logic [CW-1:0] SetLast = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TmoLast = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0] Len188 = 8'd188;
  localparam logic [7:0] Len204 = 8'd204;

  typedef enum logic [1:0] {
    RUN, DRAIN, FLUSH, SETTLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    bts_sync_q, mode_sync_q;
  logic          req_q, req_d;
  logic          boot_q, boot_d;
  logic [7:0]    len_q, len_d;
  logic          mode_q, mode_d;
  logic          hold_q, hold_d;
  logic          clr_q, clr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;
  logic [7:0]    chg_q, chg_d;

  logic s_bts, s_mode, cfg_pend;
  logic flush_entry;

  assign s_bts    = bts_sync_q[1];
  assign s_mode   = mode_sync_q[1];
  assign cfg_pend = (s_mode != mode_q) |
                    ((s_bts ? Len188 : Len204) != len_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    tmo_d   = 1'b0;
    done_d  = 1'b0;
    chg_d   = chg_q;
    unique case (state_q)
      RUN: begin
        cnt_d = '0;
        if (cfg_pend | req_q | bus.i_ReqAlteraModo) state_d = DRAIN;
      end
      DRAIN: begin
        // end-of-packet outranks the timeout on the same cycle
        if (bus.i_PktEnd) begin
          state_d = FLUSH;
        end else if (!bus.i_RdBusy && bus.i_FifoEmpty) begin
          state_d = FLUSH;
        end else if (cnt_q == TmoLast) begin
          state_d = FLUSH;
          tmo_d   = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == ClrLast) state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == SetLast) begin
          state_d = RUN;
          done_d  = 1'b1;
          chg_d   = chg_q + 8'd1;
        end
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  assign flush_entry = (state_d == FLUSH) && (state_q != FLUSH);

  always_comb begin
    req_d  = req_q | bus.i_ReqAlteraModo;
    boot_d = boot_q;
    len_d  = len_q;
    mode_d = mode_q;
    if (flush_entry) req_d = bus.i_ReqAlteraModo;
    // the startup flush keeps tracking inputs until the synchronisers fill
    if (flush_entry || (boot_q && state_q == FLUSH)) begin
      len_d  = s_bts ? Len188 : Len204;
      mode_d = s_mode;
    end
    if (state_q == FLUSH && state_d != FLUSH) boot_d = 1'b0;
    hold_d = (state_d == FLUSH) || (state_d == SETTLE);
    clr_d  = (state_d == FLUSH);
    busy_d = (state_d != RUN);
  end

  always_ff @(posedge i_Clk27Mhz or posedge i_Rst27Mhz) begin
    if (i_Rst27Mhz) begin
      state_q     <= FLUSH;
      cnt_q       <= '0;
      bts_sync_q  <= '0;
      mode_sync_q <= '0;
      req_q       <= 1'b0;
      boot_q      <= 1'b1;
      len_q       <= Len204;
      mode_q      <= 1'b0;
      hold_q      <= 1'b1;
      clr_q       <= 1'b1;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      chg_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bts_sync_q  <= {bts_sync_q[0], bus.i_BtsComp};
      mode_sync_q <= {mode_sync_q[0], bus.i_AsiMode};
      req_q       <= req_d;
      boot_q      <= boot_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      hold_q      <= hold_d;
      clr_q       <= clr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      chg_q       <= chg_d;
    end
  end

  assign bus.o_PacketLength = len_q;
  assign bus.o_AsiMode      = mode_q;
  assign bus.o_RdHold       = hold_q;
  assign bus.o_FifoClr      = clr_q;
  assign bus.o_Busy         = busy_q;
  assign bus.o_CfgDone      = done_q;
  assign bus.o_DrainTimeout = tmo_q;
  assign bus.o_ChangeCount  = chg_q;
endmodule

// File: tb/tb_asi_reconfig_sequencer.sv
// Bench for asi_reconfig_sequencer: random reconfig sequences checked
// cycle by cycle against phase-length arithmetic and a config/count model.
module tb_asi_reconfig_sequencer;
  localparam int CLR = 4;
  localparam int SET = 8;
  localparam int TMO = 408;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  int         m_cnt;
  logic [7:0] m_len;
  logic       m_mode;

  asi_reconfig_sequencer_if bus();

  asi_reconfig_sequencer #(
    .CLR_CYCLES(CLR),
    .SETTLE_CYCLES(SET),
    .DRAIN_TIMEOUT(TMO)
  ) dut (
    .i_Clk27Mhz(clk),
    .i_Rst27Mhz(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] len_of(input logic b);
    return b ? 8'd188 : 8'd204;
  endfunction

  // Trigger from an idle RUN sample; returns on the first DRAIN sample.
  task automatic start_seq(input bit use_req, input bit nb,
                           input bit nm, input string tag);
    if (use_req) begin
      bus.i_ReqAlteraModo = 1'b1;
      step;
      bus.i_ReqAlteraModo = 1'b0;
    end else begin
      bus.i_BtsComp = nb;
      bus.i_AsiMode = nm;
      for (int i = 0; i < 2; i++) begin
        step;
        total++;
        if (bus.o_Busy !== 1'b0 || bus.o_RdHold !== 1'b0) begin
          bad++;
          $display("FAIL %s sync%0d busy=%b hold=%b want 0/0",
                   tag, i, bus.o_Busy, bus.o_RdHold);
        end
      end
      step;
    end
  endtask

  // dl: 0 = idle exit, >0 = PktEnd on that DRAIN cycle, <0 = timeout.
  task automatic finish_seq(input int dl, input bit tog,
                            input string tag);
    int nd;
    nd = (dl == 0) ? 1 : ((dl > 0) ? dl : TMO);
    bus.i_RdBusy    = (dl != 0);
    bus.i_FifoEmpty = (dl == 0);
    for (int i = 1; i <= nd; i++) begin
      total++;
      if (bus.o_Busy !== 1'b1 || bus.o_RdHold !== 1'b0 ||
          bus.o_FifoClr !== 1'b0 || bus.o_DrainTimeout !== 1'b0) begin
        bad++;
        $display("FAIL %s drain%0d busy=%b hold=%b clr=%b tmo=%b want 1000",
                 tag, i, bus.o_Busy, bus.o_RdHold, bus.o_FifoClr,
                 bus.o_DrainTimeout);
      end
      bus.i_PktEnd = (dl > 0 && i == dl);
      step;
    end
    bus.i_PktEnd    = 1'b0;
    bus.i_RdBusy    = 1'b0;
    bus.i_FifoEmpty = 1'b1;
    m_len  = len_of(bus.i_BtsComp);
    m_mode = bus.i_AsiMode;
    for (int i = 1; i <= CLR; i++) begin
      total++;
      if (bus.o_Busy !== 1'b1 || bus.o_RdHold !== 1'b1 ||
          bus.o_FifoClr !== 1'b1 ||
          bus.o_DrainTimeout !== (i == 1 && dl < 0)) begin
        bad++;
        $display("FAIL %s flush%0d busy=%b hold=%b clr=%b tmo=%b want 111%b",
                 tag, i, bus.o_Busy, bus.o_RdHold, bus.o_FifoClr,
                 bus.o_DrainTimeout, (i == 1 && dl < 0));
      end
      if (i == 1) begin
        total++;
        if (bus.o_PacketLength !== m_len || bus.o_AsiMode !== m_mode) begin
          bad++;
          $display("FAIL %s load len=%0d mode=%b want %0d/%b", tag,
                   bus.o_PacketLength, bus.o_AsiMode, m_len, m_mode);
        end
      end
      step;
    end
    for (int i = 1; i <= SET; i++) begin
      total++;
      if (bus.o_Busy !== 1'b1 || bus.o_RdHold !== 1'b1 ||
          bus.o_FifoClr !== 1'b0 || bus.o_CfgDone !== 1'b0) begin
        bad++;
        $display("FAIL %s settle%0d busy=%b hold=%b clr=%b done=%b want 1100",
                 tag, i, bus.o_Busy, bus.o_RdHold, bus.o_FifoClr,
                 bus.o_CfgDone);
      end
      if (tog && i == 2) bus.i_AsiMode = ~bus.i_AsiMode;
      step;
    end
    m_cnt = (m_cnt + 1) % 256;
    total++;
    if (bus.o_Busy !== 1'b0 || bus.o_RdHold !== 1'b0 ||
        bus.o_FifoClr !== 1'b0 || bus.o_CfgDone !== 1'b1 ||
        bus.o_ChangeCount !== 8'(m_cnt) ||
        bus.o_PacketLength !== m_len || bus.o_AsiMode !== m_mode) begin
      bad++;
      $display("FAIL %s run b/h/c/d=%b%b%b%b cnt=%0d len=%0d mode=%b want 0001 %0d %0d %b",
               tag, bus.o_Busy, bus.o_RdHold, bus.o_FifoClr, bus.o_CfgDone,
               bus.o_ChangeCount, bus.o_PacketLength, bus.o_AsiMode,
               m_cnt, m_len, m_mode);
    end
  endtask

  task automatic run_seq(input bit use_req, input bit nb, input bit nm,
                         input int dl, input string tag);
    start_seq(use_req, nb, nm, tag);
    finish_seq(dl, 1'b0, tag);
    step;
    total++;
    if (bus.o_CfgDone !== 1'b0 || bus.o_Busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle done=%b busy=%b want 0/0",
               tag, bus.o_CfgDone, bus.o_Busy);
    end
  endtask

  task automatic boot_check(input string tag);
    for (int i = 0; i < CLR + SET; i++) begin
      total++;
      if (bus.o_RdHold !== 1'b1 || bus.o_Busy !== 1'b1 ||
          bus.o_FifoClr !== (i < CLR)) begin
        bad++;
        $display("FAIL %s boot%0d hold=%b busy=%b clr=%b want 11%b", tag, i,
                 bus.o_RdHold, bus.o_Busy, bus.o_FifoClr, (i < CLR));
      end
      step;
    end
    m_cnt  = 1;
    m_len  = len_of(bus.i_BtsComp);
    m_mode = bus.i_AsiMode;
    total++;
    if (bus.o_Busy !== 1'b0 || bus.o_RdHold !== 1'b0 ||
        bus.o_CfgDone !== 1'b1 || bus.o_ChangeCount !== 8'(m_cnt) ||
        bus.o_PacketLength !== m_len || bus.o_AsiMode !== m_mode) begin
      bad++;
      $display("FAIL %s boot_run b/h/d=%b%b%b cnt=%0d len=%0d mode=%b",
               tag, bus.o_Busy, bus.o_RdHold, bus.o_CfgDone,
               bus.o_ChangeCount, bus.o_PacketLength, bus.o_AsiMode);
    end
    step;
  endtask

  task automatic test_reset;
    bus.i_BtsComp       = 1'b1;
    bus.i_AsiMode       = 1'b1;
    bus.i_ReqAlteraModo = 1'b0;
    bus.i_PktEnd        = 1'b0;
    bus.i_RdBusy        = 1'b0;
    bus.i_FifoEmpty     = 1'b1;
    rst = 1'b1;
    repeat (3) step;
    total++;
    if (bus.o_PacketLength !== 8'd204 || bus.o_AsiMode !== 1'b0 ||
        bus.o_RdHold !== 1'b1 || bus.o_FifoClr !== 1'b1 ||
        bus.o_Busy !== 1'b1 || bus.o_CfgDone !== 1'b0 ||
        bus.o_DrainTimeout !== 1'b0 || bus.o_ChangeCount !== 8'd0) begin
      bad++;
      $display("FAIL reset len=%0d mode=%b h/c/b=%b%b%b d/t=%b%b cnt=%0d",
               bus.o_PacketLength, bus.o_AsiMode, bus.o_RdHold,
               bus.o_FifoClr, bus.o_Busy, bus.o_CfgDone,
               bus.o_DrainTimeout, bus.o_ChangeCount);
    end
    rst = 1'b0;
    boot_check("startup");
  endtask

  task automatic test_cfg_pktend;
    bus.i_RdBusy    = 1'b1;
    bus.i_FifoEmpty = 1'b0;
    run_seq(1'b0, 1'b0, bus.i_AsiMode, 28, "cfg_pktend");
  endtask

  task automatic test_req_idle;
    run_seq(1'b1, 1'b0, 1'b0, 0, "req_idle");
  endtask

  task automatic test_timeout;
    run_seq(1'b1, 1'b0, 1'b0, -1, "timeout");
  endtask

  task automatic test_pktend_at_timeout;
    run_seq(1'b1, 1'b0, 1'b0, TMO, "pkt_at_tmo");
  endtask

  task automatic test_random;
    bit ur, nb, nm;
    int r, dl;
    for (int k = 0; k < 20; k++) begin
      ur = 1'($urandom_range(0, 1));
      nb = 1'($urandom_range(0, 1));
      nm = 1'($urandom_range(0, 1));
      if (!ur && nb == bus.i_BtsComp && nm == bus.i_AsiMode) nb = ~nb;
      r  = int'($urandom_range(0, 9));
      dl = (r == 0) ? -1 : ((r < 4) ? 0 : int'($urandom_range(1, 60)));
      run_seq(ur, nb, nm, dl, "random");
    end
  endtask

  task automatic test_back_to_back;
    while (m_cnt != 254) run_seq(1'b1, 1'b0, 1'b0, 0, "fill");
    start_seq(1'b1, 1'b0, 1'b0, "retrig");
    finish_seq(0, 1'b1, "retrig");
    step;
    total++;
    if (bus.o_Busy !== 1'b1 || bus.o_RdHold !== 1'b0 ||
        bus.o_CfgDone !== 1'b0) begin
      bad++;
      $display("FAIL retrig_drain busy=%b hold=%b done=%b want 100",
               bus.o_Busy, bus.o_RdHold, bus.o_CfgDone);
    end
    finish_seq(0, 1'b0, "wrap");
    step;
  endtask

  task automatic test_reset_mid_flush;
    run_seq(1'b0, 1'b1, ~bus.i_AsiMode, 0, "pre_rst");
    start_seq(1'b1, 1'b0, 1'b0, "mid_rst");
    bus.i_RdBusy    = 1'b0;
    bus.i_FifoEmpty = 1'b1;
    step;
    step;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (bus.o_PacketLength !== 8'd204 || bus.o_AsiMode !== 1'b0 ||
        bus.o_RdHold !== 1'b1 || bus.o_FifoClr !== 1'b1 ||
        bus.o_Busy !== 1'b1 || bus.o_ChangeCount !== 8'd0) begin
      bad++;
      $display("FAIL async_rst len=%0d mode=%b h/c/b=%b%b%b cnt=%0d",
               bus.o_PacketLength, bus.o_AsiMode, bus.o_RdHold,
               bus.o_FifoClr, bus.o_Busy, bus.o_ChangeCount);
    end
    step;
    rst = 1'b0;
    boot_check("reboot");
  endtask

  initial begin
    m_cnt  = 0;
    m_len  = 8'd204;
    m_mode = 1'b0;
    test_reset();
    test_cfg_pktend();
    test_req_idle();
    test_timeout();
    test_pktend_at_timeout();
    test_random();
    test_back_to_back();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
